// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Round-robin arbiter that shares one LIFO stack between NREQ requesters.
// Each requester hands over a push or pop through a valid/ready handshake;
// the arbiter runs one stack operation at a time and answers the originating
// requester with a one-cycle, one-hot response carrying pop data, the echoed
// push data, or an error flag (pop while empty / push while full).
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-high
//   req_valid_i    [NREQ]        request valid, held until accepted
//   req_op_i       [NREQ]        1 = push, 0 = pop
//   req_data_i     [NREQ*WIDTH]  push data, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o    [NREQ]        one-hot accept (combinational, IDLE only)
//   rsp_valid_o    [NREQ]        one-hot response strobe
//   rsp_data_o     [WIDTH]       pop data / echoed push data / 0 on error
//   rsp_err_o                    error qualifier for rsp_valid_o
//   stk_push_o, stk_pop_o        stack strobes (EXEC only, never together)
//   stk_data_in_o  [WIDTH]       data to stack (latched request data)
//   stk_data_out_i [WIDTH]       registered stack read data
//   stk_full_i, stk_empty_i      stack flags, sampled in EXEC
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ-1:0]       req_op_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  stk_push_o,
    output logic                  stk_pop_o,
    output logic [WIDTH-1:0]      stk_data_in_o,
    input  logic [WIDTH-1:0]      stk_data_out_i,
    input  logic                  stk_full_i,
    input  logic                  stk_empty_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] last_q,     last_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             op_q,       op_d;
    logic [WIDTH-1:0] dat_q,      dat_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q,  rsp_err_d;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    int               cand;

    // Round-robin search: start just after the last grant and wrap, so the
    // requester served most recently is looked at last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!gnt_found && req_valid_i[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(NREQ - 1);
            idx_q      <= '0;
            op_q       <= 1'b0;
            dat_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            dat_q      <= dat_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        op_d        = op_q;
        dat_d       = dat_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        stk_push_o  = 1'b0;
        stk_pop_o   = 1'b0;
        // The latched request data is presented for the whole transaction,
        // not only during the push strobe.
        stk_data_in_o = (state_q == IDLE) ? '0 : dat_q;

        unique case (state_q)
            IDLE: begin
                // A grant only exists for a valid requester, so showing ready
                // is the same as accepting on this edge.
                if (gnt_found) begin
                    req_ready_o = NREQ'(1) << gnt_idx;
                    idx_d       = gnt_idx;
                    op_d        = req_op_i[gnt_idx];
                    dat_d       = req_data_i[gnt_idx*WIDTH +: WIDTH];
                    last_d      = gnt_idx;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (op_q) begin
                    if (!stk_full_i) begin
                        stk_push_o = 1'b1;
                        rsp_data_d = dat_q;
                        rsp_err_d  = 1'b0;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                    state_d = RESP;
                end else if (!stk_empty_i) begin
                    stk_pop_o = 1'b1;
                    state_d   = WAIT;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WAIT: begin
                // Stack output register was loaded by the pop edge.
                rsp_data_d = stk_data_out_i;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid_o = NREQ'(1) << idx_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  stk_push;
    logic                  stk_pop;
    logic [WIDTH-1:0]      stk_data_in;
    logic [WIDTH-1:0]      stk_data_out;
    logic                  stk_full;
    logic                  stk_empty;

    always #5 clk = ~clk;

    stack_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_data_i(req_data),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .stk_push_o(stk_push), .stk_pop_o(stk_pop),
        .stk_data_in_o(stk_data_in), .stk_data_out_i(stk_data_out),
        .stk_full_i(stk_full), .stk_empty_i(stk_empty)
    );

    // Attached stack: registered read data that updates on the pop edge.
    logic [WIDTH-1:0] smem [DEPTH];
    logic [2:0]       scnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt         <= 3'd0;
            stk_data_out <= '0;
        end else if (stk_push && scnt < 3'(DEPTH)) begin
            smem[scnt[1:0]] <= stk_data_in;
            scnt            <= scnt + 3'd1;
        end else if (stk_pop && scnt > 3'd0) begin
            stk_data_out <= smem[2'(scnt - 3'd1)];
            scnt         <= scnt - 3'd1;
        end
    end
    assign stk_full  = (scnt == 3'(DEPTH));
    assign stk_empty = (scnt == 3'd0);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain LIFO queue plus round-robin pointer.
    typedef struct {
        int             idx;
        logic [WIDTH-1:0] data;
        logic           err;
        int             cyc;
    } exp_t;

    logic [WIDTH-1:0] ref_stk [$];
    exp_t             sb [$];
    int               grant_log [$];
    int               last_ref      = NREQ - 1;
    int               busy_from     = -10;
    int               busy_until    = -10;
    int               exp_push_cyc  = -10;
    int               exp_pop_cyc   = -10;
    logic [WIDTH-1:0] exp_push_data = '0;
    logic [WIDTH-1:0] cur_dat       = '0;
    logic [NREQ-1:0]  acc_mask      = '0;

    // Stimulus side: predicts grants, strobes and responses at each accept.
    always @(negedge clk) begin : tracker
        int g, c, ga;
        logic [NREQ-1:0] exp_ready;
        exp_t e;
        if (rst !== 1'b0) begin
            acc_mask = '0;
        end else begin
            chk("stk_push", stk_push, cyc == exp_push_cyc);
            if (cyc == exp_push_cyc) chk("stk_data_in_push", stk_data_in, exp_push_data);
            chk("stk_pop", stk_pop, cyc == exp_pop_cyc);
            chk("stk_data_in", stk_data_in,
                (cyc >= busy_from && cyc <= busy_until) ? cur_dat : '0);

            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (last_ref + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_ready = '0;
            if (cyc > busy_until && g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);

            acc_mask = req_valid & req_ready;
            ga = -1;
            for (int i = 0; i < NREQ; i++) if (acc_mask[i]) ga = i;
            if (ga >= 0) begin
                last_ref = ga;
                grant_log.push_back(ga);
                cur_dat   = req_data[ga*WIDTH +: WIDTH];
                busy_from = cyc + 1;
                e.idx = ga;
                if (req_op[ga]) begin
                    if (ref_stk.size() < DEPTH) begin
                        ref_stk.push_back(cur_dat);
                        e.data = cur_dat; e.err = 1'b0;
                        exp_push_cyc  = cyc + 1;
                        exp_push_data = cur_dat;
                    end else begin
                        e.data = '0; e.err = 1'b1;
                    end
                    e.cyc = cyc + 2;
                end else begin
                    if (ref_stk.size() > 0) begin
                        e.data = ref_stk.pop_back(); e.err = 1'b0;
                        exp_pop_cyc = cyc + 1;
                        e.cyc = cyc + 3;
                    end else begin
                        e.data = '0; e.err = 1'b1;
                        e.cyc = cyc + 2;
                    end
                end
                busy_until = e.cyc;
                sb.push_back(e);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [NREQ-1:0] ev;
        if (rst === 1'b0) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, '0);
                end else begin
                    e  = sb.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("rsp_valid", rsp_valid, ev);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 32'd0, 32'd1);
            end
        end
    end

    task automatic do_req(input int i, input logic op, input logic [WIDTH-1:0] d);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_data[i*WIDTH +: WIDTH] = d;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (acc_mask[i]) begin
                req_valid[i] = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask;
            if (req_valid == '0) return;
        end
        chk("drain_timeout", req_valid, '0);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_stk_push", stk_push, 1'b0);
        chk("rst_stk_pop", stk_pop, 1'b0);
        chk("rst_stk_data_in", stk_data_in, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single push, then empty the stack again.
        do_req(1, 1'b1, 8'hA5);
        do_req(0, 1'b0, 8'h00);
        // Two pushes then a pop from another requester.
        do_req(0, 1'b1, 8'h11);
        do_req(2, 1'b1, 8'h22);
        do_req(3, 1'b0, 8'h00);
        do_req(0, 1'b0, 8'h00);
        // Pop on empty.
        do_req(2, 1'b0, 8'h00);
        // Fill, overflow push, pop returns last accepted value.
        for (int k = 0; k < DEPTH; k++) do_req(k % NREQ, 1'b1, 8'(8'h40 + k));
        do_req(1, 1'b1, 8'h7E);
        do_req(2, 1'b0, 8'h00);
        for (int k = 0; k < DEPTH - 1; k++) do_req(3, 1'b0, 8'h00);

        // All requesters hold pushes continuously.
        base = grant_log.size();
        req_op = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 8'($urandom) | 8'h01;
        req_valid = '1;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++)
                if (acc_mask[i]) req_data[i*WIDTH +: WIDTH] = 8'($urandom) | 8'h01;
        end
        drain();
        for (int k = 0; k < 6; k++) chk("grant_order", grant_log[base+k], k % NREQ);
        repeat (4) @(posedge clk); #1;

        // Reset during the WAIT cycle of a pop.
        do_req(1, 1'b0, 8'h00);
        do_req(2, 1'b0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        ref_stk.delete(); sb.delete();
        last_ref = NREQ - 1;
        busy_from = -10; busy_until = -10; exp_push_cyc = -10; exp_pop_cyc = -10;
        #1;
        chk("midrst_rsp_valid", rsp_valid, '0);
        chk("midrst_rsp_data", rsp_data, '0);
        chk("midrst_rsp_err", rsp_err, 1'b0);
        chk("midrst_stk_push", stk_push, 1'b0);
        chk("midrst_stk_pop", stk_pop, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_op = '1;
        req_data = {8'h54, 8'h53, 8'h52, 8'h51};
        req_valid = '1;
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        drain();

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_op[i]    = 1'($urandom_range(0, 1));
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
        end
        drain();
        repeat (5) @(posedge clk); #1;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Round-robin arbiter that shares a single LIFO stack instance between NREQ independent requesters. Each requester issues push or pop transactions through a valid/ready handshake. The arbiter serialises the transactions onto the stack's push/pop/full/empty interface and returns a one-hot response with pop data or an error flag. It sits directly in front of the team's stack block; the stack's data_out is registered and updates on the edge that performs the pop.

## Interface

- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: data width; must match the attached stack
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid; must be held until accepted
- req_op  in  NREQ  per-requester operation: 1 = push, 0 = pop
- req_data  in  NREQ*WIDTH  push data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept; a request is accepted on an edge where req_valid[i] and req_ready[i] are both 1
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe to the originating requester
- rsp_data  out  WIDTH  popped data (pop), echoed data (push), or 0 (error)
- rsp_err  out  1  qualifies rsp_valid: 1 = pop while empty or push while full
- stk_push  out  1  push strobe to the stack
- stk_pop  out  1  pop strobe to the stack
- stk_data_in  out  WIDTH  data to the stack
- stk_data_out  in  WIDTH  stack read data (registered inside the stack)
- stk_full  in  1  stack full flag
- stk_empty  in  1  stack empty flag

## Operation

- FSM states: IDLE, EXEC, WAIT, RESP. Reset state is IDLE.
- IDLE
  - Scan req_valid starting at index (last+1) mod NREQ, wrapping; the first set bit is the grant g.
  - req_ready[g] = 1 combinationally; all other bits are 0.
  - On the accept edge: latch g, req_op[g] and req_data slice g into idx/op/dat; set last = g; go to EXEC.
  - If no req_valid bit is set, req_ready = 0 and the FSM stays in IDLE.
- EXEC
  - push and !stk_full: stk_push = 1, stk_data_in = dat; load rsp_data = dat, rsp_err = 0; go to RESP.
  - push and stk_full: no strobe; rsp_data = 0, rsp_err = 1; go to RESP.
  - pop and !stk_empty: stk_pop = 1; go to WAIT.
  - pop and stk_empty: no strobe; rsp_data = 0, rsp_err = 1; go to RESP.
- WAIT: capture stk_data_out into rsp_data, rsp_err = 0; go to RESP.
- RESP: rsp_valid[idx] = 1; go to IDLE.
- req_ready is 0 in every state except IDLE, so at most one stack operation is outstanding.
- stk_push and stk_pop are never asserted together and never outside EXEC. stk_data_in = dat whenever the FSM is not in IDLE, and 0 otherwise.
- Round-robin pointer last resets to NREQ-1, so requester 0 has first priority after reset. A requester that has just been granted has lowest priority on the next arbitration.
- Reset values: state = IDLE; last = NREQ-1; idx, op, dat = 0; rsp_data = 0; rsp_err = 0. All outputs are therefore 0 during and immediately after reset, except req_ready, which is the combinational IDLE grant. rst overrides everything asynchronously.
- Reset mid-operation: an in-flight transaction is dropped with no rsp_valid. A push strobe already sampled by the stack remains committed; rst normally resets the stack as well.

## Timing

- Accept edge = cycle 0.
- Push: stk_push high in cycle 1; rsp_valid in cycle 2. Next accept is possible at the end of cycle 3.
- Pop: stk_pop high in cycle 1; stack data valid in cycle 2 (WAIT); rsp_valid and rsp_data in cycle 3.
- Error: no strobe; rsp_valid in cycle 2.
- rsp_data and rsp_err are held stable from the start of RESP until the next response is loaded.
- Throughput: one transaction per 3 cycles (push or error) or 4 cycles (pop).
- Stack flags are sampled in EXEC only; they reflect all previously completed operations.

## Test plan

- Reset, requester 1 pushes 0xA5 -> req_ready = 0010 on the accept edge; stk_push = 1 with stk_data_in = 0xA5 in cycle 1; rsp_valid = 0010, rsp_data = 0xA5, rsp_err = 0 in cycle 2.
- Requester 0 pushes 0x11, requester 2 pushes 0x22, then requester 3 pops -> requester 3 gets rsp_valid = 1000, rsp_data = 0x22 three cycles after its accept; the stack then holds only 0x11.
- Pop on an empty stack from requester 2 -> stk_pop never asserted; rsp_valid = 0100, rsp_err = 1, rsp_data = 0x00 in cycle 2.
- Push until stk_full = 1, then push 0x7E -> stk_push stays 0; rsp_err = 1; a following pop returns the last accepted value, not 0x7E.
- All four requesters hold push requests continuously after reset -> grant order 0,1,2,3,0,1; exactly one req_ready bit per IDLE cycle; no grant while the FSM is busy.
- Assert rst in the WAIT cycle of a pop -> rsp_valid, rsp_data, rsp_err, stk_push and stk_pop go to 0 immediately; no response is issued; after release, requester 0 wins arbitration first.
